cnt2note: RTL and testbench

//  Pitch decoder, inverse of the note-to-half-period oscillator mapping.
//  - Measures the half period of square wave sig_i in clk_i cycles.
//  - Normalises the count into the 8-bit base-octave range.
//  - Finds the nearest entry of the 12-entry base ROM and emits a MIDI note number (21..127).
//  - Sits on the tuner/loopback path that checks the oscillator output.

---
 rtl/cnt2note.sv | 211 +++++++++++++++++++++
 tb/tb_cnt2note.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cnt2note.sv
// Pitch decoder: measures the half period of sig_i and maps it to the nearest MIDI note.
// Optional CNT2NOTE_AVG_EN averages consecutive half periods to cancel duty-cycle skew.
module cnt2note #(
    parameter int BW = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       sig_i,
    output logic [7:0] note_o,
    output logic       noteValid_o,
    output logic       oor_o,
    output logic       busy_o
);
    localparam int VW = BW + 1;
    localparam int SW = $clog2(VW + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MEAS = 3'd1;
    localparam logic [2:0] S_NORM = 3'd2;
    localparam logic [2:0] S_SRCH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    sync_q;
    logic [2:0]    state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] v_q, v_d;
    logic [SW-1:0] s_q, s_d;
    logic          sat_q, sat_d;
    logic [3:0]    j_q, j_d;
    logic [3:0]    bestj_q, bestj_d;
    logic [8:0]    bestd_q, bestd_d;
    logic [7:0]    note_q, note_d;
    logic          oor_q, oor_d;
    logic          vld_q, vld_d;
`ifdef CNT2NOTE_AVG_EN
    logic [BW-1:0] hprev_q, hprev_d;
    logic          hvld_q, hvld_d;
`endif

    logic       edge_w;
    logic [8:0] cand_w, dist_w, oct_w, note9_w;
    logic       better_w;
    logic [3:0] selj_w;

    // Candidate j maps to note index j-1: octave-up wrap, base ROM, octave-down wrap.
    function automatic logic [8:0] cand(input logic [3:0] j);
        case (j)
            4'd0:    cand = 9'd262;
            4'd1:    cand = 9'd248;
            4'd2:    cand = 9'd234;
            4'd3:    cand = 9'd221;
            4'd4:    cand = 9'd209;
            4'd5:    cand = 9'd197;
            4'd6:    cand = 9'd186;
            4'd7:    cand = 9'd175;
            4'd8:    cand = 9'd165;
            4'd9:    cand = 9'd156;
            4'd10:   cand = 9'd147;
            4'd11:   cand = 9'd139;
            4'd12:   cand = 9'd131;
            default: cand = 9'd124;
        endcase
    endfunction

    assign edge_w   = sync_q[2] ^ sync_q[1];
    assign cand_w   = cand(j_q);
    // V is below 256 once SEARCH is reached, so 9 bits cover the distance.
    assign dist_w   = (v_q[8:0] >= cand_w) ? v_q[8:0] - cand_w : cand_w - v_q[8:0];
    assign better_w = dist_w < bestd_q;
    assign selj_w   = better_w ? j_q : bestj_q;
    assign oct_w    = 9'd8 - 9'(s_q);
    assign note9_w  = 9'd20 + oct_w * 9'd12 + {5'd0, selj_w};

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == {BW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        v_d     = v_q;
        s_d     = s_q;
        sat_d   = sat_q;
        j_d     = j_q;
        bestj_d = bestj_q;
        bestd_d = bestd_q;
        note_d  = note_q;
        oor_d   = oor_q;
        vld_d   = 1'b0;
`ifdef CNT2NOTE_AVG_EN
        hprev_d = hprev_q;
        hvld_d  = hvld_q;
`endif
        if (edge_w) cnt_d = {{(BW-1){1'b0}}, 1'b1};

        case (state_q)
            S_IDLE: if (edge_w) state_d = S_MEAS;
            S_MEAS: begin
                if (edge_w) begin
                    s_d = '0;
`ifdef CNT2NOTE_AVG_EN
                    hprev_d = cnt_q;
                    if (hvld_q) begin
                        v_d     = (VW'(hprev_q) + VW'(cnt_q)) >> 1;
                        sat_d   = (cnt_q == {BW{1'b1}}) || (hprev_q == {BW{1'b1}});
                        state_d = S_NORM;
                    end else begin
                        hvld_d = 1'b1;
                    end
`else
                    v_d     = VW'(cnt_q);
                    sat_d   = (cnt_q == {BW{1'b1}});
                    state_d = S_NORM;
`endif
                end
            end
            S_NORM: begin
                if (edge_w) begin
                    state_d = S_MEAS;
                end else if (v_q >= VW'(256)) begin
                    v_d = v_q >> 1;
                    s_d = s_q + 1'b1;
                end else if (sat_q || s_q > SW'(8) || (s_q == '0 && v_q < VW'(128))) begin
                    oor_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    j_d     = '0;
                    bestj_d = '0;
                    bestd_d = '1;
                    state_d = S_SRCH;
                end
            end
            S_SRCH: begin
                if (edge_w) begin
                    state_d = S_MEAS;
                end else begin
                    if (better_w) begin
                        bestd_d = dist_w;
                        bestj_d = j_q;
                    end
                    j_d = j_q + 4'd1;
                    if (j_q == 4'd13) begin
                        vld_d   = 1'b1;
                        state_d = S_DONE;
                        if (note9_w < 9'd21 || note9_w > 9'd127) begin
                            oor_d = 1'b1;
                        end else begin
                            oor_d  = 1'b0;
                            note_d = note9_w[7:0];
                        end
                    end
                end
            end
            S_DONE:  state_d = S_MEAS;
            default: state_d = S_IDLE;
        endcase

        if (!en_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            vld_d   = 1'b0;
        end
`ifdef CNT2NOTE_AVG_EN
        // Any interrupted or out-of-range decode breaks the averaging chain.
        if (!en_i || (vld_d && oor_d) ||
            (state_d == S_MEAS && (state_q == S_NORM || state_q == S_SRCH)))
            hvld_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            v_q     <= '0;
            s_q     <= '0;
            sat_q   <= 1'b0;
            j_q     <= '0;
            bestj_q <= '0;
            bestd_q <= '0;
            note_q  <= '0;
            oor_q   <= 1'b0;
            vld_q   <= 1'b0;
`ifdef CNT2NOTE_AVG_EN
            hprev_q <= '0;
            hvld_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[1:0], sig_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            s_q     <= s_d;
            sat_q   <= sat_d;
            j_q     <= j_d;
            bestj_q <= bestj_d;
            bestd_q <= bestd_d;
            note_q  <= note_d;
            oor_q   <= oor_d;
            vld_q   <= vld_d;
`ifdef CNT2NOTE_AVG_EN
            hprev_q <= hprev_d;
            hvld_q  <= hvld_d;
`endif
        end
    end

    assign note_o      = note_q;
    assign oor_o       = oor_q;
    assign noteValid_o = vld_q;
    assign busy_o      = (state_q == S_NORM) || (state_q == S_SRCH) || (state_q == S_DONE);
endmodule

// File: tb/tb_cnt2note.sv
// Scoreboard bench for cnt2note: stimulus pushes expected decodes, monitors pop on noteValid_o.
module tb_cnt2note;
    logic       clk = 1'b0;
    logic       rst, en, sig, sig2;
    logic [7:0] note, note2;
    logic       vld, oor, busy, vld2, oor2, busy2;

    always #5 clk = ~clk;

    cnt2note #(.BW(16)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sig_i(sig),
        .note_o(note), .noteValid_o(vld), .oor_o(oor), .busy_o(busy)
    );

    // Narrow counter so saturation is reachable in a short run.
    cnt2note #(.BW(10)) u_sat (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sig_i(sig2),
        .note_o(note2), .noteValid_o(vld2), .oor_o(oor2), .busy_o(busy2)
    );

    typedef struct {
        logic [7:0] note;
        logic       oor;
        int         due;
    } exp_t;

    exp_t       q1[$];
    exp_t       q2[$];
    exp_t       m1, m2;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_note;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Wait p cycles then toggle sig; optionally queue the expected decode.
    task automatic half(input int p, input bit push, input logic [7:0] n, input logic o,
                        input int lat);
        exp_t e;
        repeat (p) @(posedge clk);
        #1 sig = ~sig;
        if (push) begin
            e.note = o ? last_note : n;
            e.oor  = o;
            e.due  = (lat >= 0) ? cyc + lat : -1;
            q1.push_back(e);
            if (!o) last_note = n;
        end
    endtask

    always @(negedge clk) begin
        if (vld === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid note=%0d oor=%0d (cycle %0d)", note, oor, cyc);
            end else begin
                m1 = q1.pop_front();
                chk("oor", int'(oor), int'(m1.oor));
                chk("note", int'(note), int'(m1.note));
                if (m1.due >= 0) chk("latency", cyc, m1.due);
            end
        end
    end

    always @(negedge clk) begin
        if (vld2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_sat note=%0d oor=%0d (cycle %0d)", note2, oor2, cyc);
            end else begin
                m2 = q2.pop_front();
                chk("sat_oor", int'(oor2), int'(m2.oor));
                chk("sat_note", int'(note2), int'(m2.note));
            end
        end
    end

    initial begin
        exp_t e2;
        sig = 1'b0; sig2 = 1'b0; en = 1'b0; rst = 1'b1; last_note = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_note", int'(note), 0);
        chk("rst_oor", int'(oor), 0);
        chk("rst_valid", int'(vld), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0; en = 1'b1;

        half(10, 0, 8'd0, 1'b0, -1);          // first edge only arms the measurement
`ifdef CNT2NOTE_AVG_EN
        half(3900, 0, 8'd0, 1'b0, -1);        // loads H_prev only
        half(4036, 1, 8'd69, 1'b0, -1);       // avg 3968 -> 248<<4
        half(3968, 1, 8'd69, 1'b0, -1);       // avg 4002 -> 250, nearest 248
`else
        // 248<<4: 4 shifts, exact ROM hit; sync adds 2 cycles to k+16.
        half(3968, 1, 8'd69, 1'b0, 22);
        half(3970, 1, 8'd69, 1'b0, -1);
        half(3712, 1, 8'd70, 1'b0, -1);       // 232: 234 nearest
        half(139, 1, 8'd127, 1'b0, -1);       // top of range
        half(131, 1, 8'd0, 1'b1, -1);         // would be 128
        half(100, 1, 8'd0, 1'b1, -1);         // below 128
        half(255, 1, 8'd116, 1'b0, -1);       // tie 262/248 keeps 262
        half(254, 1, 8'd117, 1'b0, -1);       // 248 nearer
        half(63488, 1, 8'd21, 1'b0, -1);      // 248<<8: lowest note
        half(3900, 1, 8'd69, 1'b0, -1);       // 243 -> 248
        half(4036, 1, 8'd69, 1'b0, -1);       // 252 -> 248

        // Edge during NORM drops that decode; following half period is clean.
        half(992, 0, 8'd0, 1'b0, -1);
        half(2, 0, 8'd0, 1'b0, -1);
        half(992, 1, 8'd93, 1'b0, -1);        // 248<<2

        // Reset in SEARCH: no pulse and outputs cleared.
        half(992, 0, 8'd0, 1'b0, -1);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1; sig = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("srch_rst_note", int'(note), 0);
        chk("srch_rst_oor", int'(oor), 0);
        chk("srch_rst_valid", int'(vld), 0);
        chk("srch_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0; last_note = 8'd0;
        repeat (40) @(posedge clk);
        half(5, 0, 8'd0, 1'b0, -1);
        half(992, 1, 8'd93, 1'b0, -1);

        // Enable low in SEARCH discards the result and returns to IDLE.
        half(992, 0, 8'd0, 1'b0, -1);
        repeat (12) @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("en_low_busy", int'(busy), 0);
        @(posedge clk);
        #1 en = 1'b1;
        repeat (20) @(posedge clk);
        half(20, 0, 8'd0, 1'b0, -1);
        half(139, 1, 8'd127, 1'b0, -1);

        // Stuck input saturates the counter; the eventual edge reports out of range.
        @(posedge clk);
        #1 sig2 = 1'b1;
        repeat (1100) @(posedge clk);
        #1 sig2 = 1'b0;
        e2.note = 8'd0; e2.oor = 1'b1; e2.due = -1;
        q2.push_back(e2);
`endif

        for (int i = 0; i < 300 && (q1.size() + q2.size()) > 0; i++) @(posedge clk);
        repeat (30) @(posedge clk);
        chk("pending_results", q1.size() + q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
